// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

  localparam int RV_INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'b000,
    IMM_I     = 3'b001,
    IMM_S     = 3'b010,
    IMM_B     = 3'b011,
    IMM_U     = 3'b100,
    IMM_J     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_RSVD  = 3'b111
  } imm_src_e;

endpackage

// File: rtl/imm_decode.sv
// RV32I immediate decoder: instr + format select -> sign/zero-extended immediate.
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: instr (raw word), imm_src (imm_src_e) in; imm (D_WIDTH), err (reserved format) out.
module imm_decode
  import imm_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [RV_INSTR_W-1:0] instr,
  input  logic [2:0]            imm_src,
  output logic [D_WIDTH-1:0]    imm,
  output logic                  err
);

  logic [31:0] imm32;
  logic        unused_opcode;

  // Opcode bits never contribute to any immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    err   = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm32 = {instr[31:12], 12'b0};
      IMM_J:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: imm32 = {27'b0, instr[24:20]};
      IMM_RSVD:  err   = 1'b1;
      default:   imm32 = '0;
    endcase
  end

  // imm32[31] is already the correct extension bit for every format
  // (zero for SHAMT/NONE/RSVD), so widening just replicates it.
  generate
    if (D_WIDTH > 32) begin : g_wide
      assign imm = {{(D_WIDTH-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/imm_gen_queue.sv
// Immediate generator with a DEPTH-entry output queue between decode and execute.
// Latency: 1 cycle push-to-head when empty; outputs come from registered queue state.
// Backpressure: in_ready = not full, from registered count only (no path from out_ready).
// Ports: clk, rst (async high), flush (sync clear); in_valid/in_ready/instr/imm_src push side;
//        out_valid/out_ready/imm_ext/imm_fmt/imm_err pop side (all zero when queue empty).
module imm_gen_queue
  import imm_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RV_INSTR_W-1:0] instr,
  input  logic [2:0]            imm_src,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D_WIDTH-1:0]    imm_ext,
  output logic [2:0]            imm_fmt,
  output logic                  imm_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [D_WIDTH-1:0] mem_imm [DEPTH];
  logic [2:0]         mem_fmt [DEPTH];
  logic               mem_err [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic [D_WIDTH-1:0] dec_imm;
  logic               dec_err;
  logic               push, pop;

  imm_decode #(.D_WIDTH(D_WIDTH)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);

  // A flush cycle discards both sides of the handshake.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr] <= dec_imm;
      mem_fmt[wr_ptr] <= imm_src;
      mem_err[wr_ptr] <= dec_err;
    end
  end

  assign imm_ext = out_valid ? mem_imm[rd_ptr] : '0;
  assign imm_fmt = out_valid ? mem_fmt[rd_ptr] : 3'b000;
  assign imm_err = out_valid ? mem_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_queue.sv
// Self-checking bench: two instances (32- and 64-bit) share stimulus; a queue model checks both.
// Latency: model advances once per clock edge, outputs compared mid-cycle.
// Backpressure: out_ready driven randomly and in directed stall sequences.
module tb_imm_gen_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        out_ready;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] imm_ext32;
  logic [2:0]  imm_fmt32;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_ext64;
  logic [2:0]  imm_fmt64;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        err;
  } entry_t;

  entry_t model_q[$];

  always #5 clk = ~clk;

  imm_gen_queue #(.D_WIDTH(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_ext(imm_ext32), .imm_fmt(imm_fmt32), .imm_err(imm_err32)
  );

  imm_gen_queue #(.D_WIDTH(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_ext(imm_ext64), .imm_fmt(imm_fmt64), .imm_err(imm_err64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference immediate, built with arithmetic shifts on the sign-extended word.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src);
    logic signed [63:0] sx;
    logic [63:0] sgn;
    sx  = {{32{w[31]}}, w};
    sgn = 64'(sx >>> 63);
    case (src)
      3'd1: ref_imm = 64'(sx >>> 20);
      3'd2: ref_imm = (sgn << 11) | (64'(w[30:25]) << 5) | 64'(w[11:7]);
      3'd3: ref_imm = (sgn << 12) | (64'(w[7]) << 11) | (64'(w[30:25]) << 5) | (64'(w[11:8]) << 1);
      3'd4: ref_imm = 64'(sx) & ~64'hFFF;
      3'd5: ref_imm = (sgn << 20) | (64'(w[19:12]) << 12) | (64'(w[20]) << 11) | (64'(w[30:21]) << 1);
      3'd6: ref_imm = 64'(w[24:20]);
      default: ref_imm = 64'd0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic        ev;
    logic [63:0] eimm;
    logic [2:0]  efmt;
    logic        eerr;
    ev   = (model_q.size() != 0);
    eimm = ev ? model_q[0].imm : 64'd0;
    efmt = ev ? model_q[0].fmt : 3'd0;
    eerr = ev ? model_q[0].err : 1'b0;
    chk({tag, ".out_valid32"}, 64'(out_valid32), 64'(ev));
    chk({tag, ".out_valid64"}, 64'(out_valid64), 64'(ev));
    chk({tag, ".in_ready32"},  64'(in_ready32),  64'(model_q.size() < DEPTH));
    chk({tag, ".in_ready64"},  64'(in_ready64),  64'(model_q.size() < DEPTH));
    chk({tag, ".imm_ext32"},   64'(imm_ext32),   {32'd0, eimm[31:0]});
    chk({tag, ".imm_ext64"},   imm_ext64,        eimm);
    chk({tag, ".imm_fmt"},     64'(imm_fmt32),   64'(efmt));
    chk({tag, ".imm_fmt64"},   64'(imm_fmt64),   64'(efmt));
    chk({tag, ".imm_err"},     64'(imm_err32),   64'(eerr));
    chk({tag, ".imm_err64"},   64'(imm_err64),   64'(eerr));
  endtask

  // Drive one cycle of inputs (called at negedge), advance model, check at next negedge.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] w,
                       input logic [2:0] src, input logic ordy, input logic fl);
    bit do_push, do_pop;
    entry_t e;
    in_valid  = iv;
    instr     = w;
    imm_src   = src;
    out_ready = ordy;
    flush     = fl;
    do_push = iv && (model_q.size() < DEPTH);
    do_pop  = ordy && (model_q.size() != 0);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.imm = ref_imm(w, src);
        e.fmt = src;
        e.err = (src == 3'd7);
        model_q.push_back(e);
      end
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs("idle");

    // 1: addi x1,x0,-1 visible one cycle after push.
    cycle("t1", 1'b1, 32'hFFF00093, 3'd1, 1'b1, 1'b0);
    chk("t1.valid", 64'(out_valid32), 64'd1);
    chk("t1.imm", 64'(imm_ext32), 64'h0000_0000_FFFF_FFFF);

    // 2: B, U, J back to back with consumer always ready.
    cycle("t2b", 1'b1, 32'hFE101EE3, 3'd3, 1'b1, 1'b0);
    chk("t2.b", 64'(imm_ext32), 64'h0000_0000_FFFF_FFFC);
    cycle("t2u", 1'b1, 32'h123450B7, 3'd4, 1'b1, 1'b0);
    chk("t2.u", 64'(imm_ext32), 64'h0000_0000_1234_5000);
    cycle("t2j", 1'b1, 32'h0080006F, 3'd5, 1'b1, 1'b0);
    chk("t2.j", 64'(imm_ext32), 64'h0000_0000_0000_0008);
    cycle("t2d", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    chk("t2.drain", 64'(out_valid32), 64'd0);

    // 3: stalled consumer, three pushes; third is refused.
    cycle("t3p1", 1'b1, 32'h00100093, 3'd1, 1'b0, 1'b0);
    cycle("t3p2", 1'b1, 32'h00200093, 3'd1, 1'b0, 1'b0);
    chk("t3.full", 64'(in_ready32), 64'd0);
    cycle("t3p3", 1'b1, 32'h00300093, 3'd1, 1'b0, 1'b0);
    chk("t3.head", 64'(imm_ext32), 64'd1);
    cycle("t3q1", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    chk("t3.rdy_back", 64'(in_ready32), 64'd1);
    chk("t3.second", 64'(imm_ext32), 64'd2);
    cycle("t3q2", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    chk("t3.empty", 64'(out_valid32), 64'd0);

    // 4: reserved format still queued, flagged as error.
    cycle("t4", 1'b1, 32'hDEADBEEF, 3'd7, 1'b0, 1'b0);
    chk("t4.imm", imm_ext64, 64'd0);
    chk("t4.err", 64'(imm_err32), 64'd1);
    chk("t4.fmt", 64'(imm_fmt32), 64'd7);

    // 5: fill, then flush with a concurrent push.
    cycle("t5fill", 1'b1, 32'h00500093, 3'd1, 1'b0, 1'b0);
    cycle("t5flush", 1'b1, 32'h00600093, 3'd1, 1'b1, 1'b1);
    chk("t5.flushed", 64'(out_valid32), 64'd0);
    chk("t5.ready", 64'(in_ready32), 64'd1);
    cycle("t5a", 1'b1, 32'h00700093, 3'd1, 1'b0, 1'b0);
    cycle("t5b", 1'b1, 32'h00800093, 3'd1, 1'b0, 1'b0);
    // Async reset between edges: outputs must clear without a clock.
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    chk("t5.rst_valid", 64'(out_valid64), 64'd0);
    chk("t5.rst_imm", imm_ext64, 64'd0);
    chk("t5.rst_ready", 64'(in_ready64), 64'd1);
    @(negedge clk);
    check_outputs("t5rst");
    rst = 1'b0;

    // 6: 64-bit extension of S and SHAMT.
    cycle("t6s", 1'b1, 32'h80000023, 3'd2, 1'b1, 1'b0);
    chk("t6.s64", imm_ext64, 64'hFFFF_FFFF_FFFF_F800);
    cycle("t6sh", 1'b1, 32'h01F0D093, 3'd6, 1'b1, 1'b0);
    chk("t6.shamt64", imm_ext64, 64'h0000_0000_0000_001F);
    cycle("t6d", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", 1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
